cargador_bloque: RTL and testbench

Upstream loader for the mining datapath. It accepts a block header and a difficulty target as a byte stream over a valid/ready handshake and assembles the 96-bit block and the 8-bit target. It then clears the downstream mining stage, holds `inicio` high until that stage reports `terminado`, and signals completion or timeout. Its outputs connect directly to `bloque_bytes`, `target`, `inicio` and the active-low `reset` of the mining stage.

---
 rtl/cargador_bloque_pkg.sv | 27 ++
 rtl/cargador_bloque.sv | 127 ++++++++++++
 tb/tb_cargador_bloque.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/cargador_bloque_pkg.sv
// Shared definitions for the block loader and the mining stage it feeds:
// FSM encoding, datapath widths and the saturating timer increment.
package cargador_bloque_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CARGA   = 3'd1,
        LIMPIA  = 3'd2,
        EJECUTA = 3'd3,
        FIN     = 3'd4
    } estado_t;

    localparam int N_BYTES_BLOQUE = 12;
    localparam int ANCHO_HASH     = 24;
    localparam int ANCHO_NONCE    = 32;
    localparam int ANCHO_TIMER    = 32;

    // Holds at all-ones instead of wrapping so a stuck run can never look fresh.
    function automatic logic [ANCHO_TIMER-1:0] incr_sat(input logic [ANCHO_TIMER-1:0] valor);
        if (valor == {ANCHO_TIMER{1'b1}}) begin
            incr_sat = valor;
        end else begin
            incr_sat = valor + 32'd1;
        end
    endfunction

endpackage

// File: rtl/cargador_bloque.sv
// Byte-stream loader: assembles block + target, clears the mining stage for one
// cycle, runs it until terminado or timeout, then pulses hecho.
module cargador_bloque
    import cargador_bloque_pkg::*;
#(
    parameter int N_BYTES = N_BYTES_BLOQUE,
    parameter int TIMEOUT = 1048576
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    input  logic                 terminado,
    output logic [8*N_BYTES-1:0] bloque_bytes,
    output logic [7:0]           target,
    output logic                 inicio,
    output logic                 reset_mineria,
    output logic                 hecho,
    output logic                 error
);

    localparam int                     ANCHO_CARGA = 8 * (N_BYTES + 1);
    localparam logic [3:0]             CUENTA_ULT  = 4'(N_BYTES);
    localparam logic [ANCHO_TIMER-1:0] TIMER_ULT   = 32'(TIMEOUT - 1);

    estado_t                 estado_r, estado_s;
    logic [3:0]              cuenta_r, cuenta_s;
    logic [ANCHO_TIMER-1:0]  timer_r, timer_s;
    logic [ANCHO_CARGA-1:0]  carga_r, carga_s;
    logic                    error_r, error_s;
    logic                    reset_mineria_r, reset_mineria_s;
    logic                    byte_ready_s;
    logic                    transfer_s;

    assign byte_ready_s  = (estado_r == IDLE) || (estado_r == CARGA);
    assign transfer_s    = byte_valid & byte_ready_s;

    assign byte_ready    = byte_ready_s;
    assign inicio        = (estado_r == EJECUTA);
    assign hecho         = (estado_r == FIN);
    assign error         = error_r;
    assign reset_mineria = reset_mineria_r;
    assign bloque_bytes  = carga_r[ANCHO_CARGA-1:8];
    assign target        = carga_r[7:0];

    // Next-state, counter, timer, shift register and error flag.
    always_comb begin
        estado_s = estado_r;
        cuenta_s = cuenta_r;
        timer_s  = timer_r;
        error_s  = error_r;

        if (transfer_s) begin
            carga_s = {carga_r[ANCHO_CARGA-9:0], byte_in};
        end else begin
            carga_s = carga_r;
        end

        case (estado_r)
            IDLE: begin
                if (transfer_s) begin
                    estado_s = CARGA;
                    cuenta_s = 4'd1;
                end else begin
                    cuenta_s = 4'd0;
                end
            end
            CARGA: begin
                if (transfer_s && (cuenta_r == CUENTA_ULT)) begin
                    estado_s = LIMPIA;
                    cuenta_s = 4'd0;
                    error_s  = 1'b0;
                end else if (transfer_s) begin
                    cuenta_s = cuenta_r + 4'd1;
                end else begin
                    cuenta_s = cuenta_r;
                end
            end
            LIMPIA: begin
                estado_s = EJECUTA;
                timer_s  = '0;
            end
            EJECUTA: begin
                timer_s = incr_sat(timer_r);
                // terminado has priority so a run finishing on the last cycle is not flagged.
                if (terminado) begin
                    estado_s = FIN;
                end else if (timer_r == TIMER_ULT) begin
                    estado_s = FIN;
                    error_s  = 1'b1;
                end else begin
                    estado_s = EJECUTA;
                end
            end
            FIN: begin
                estado_s = IDLE;
            end
            default: begin
                estado_s = IDLE;
                cuenta_s = 4'd0;
            end
        endcase

        reset_mineria_s = (estado_s != LIMPIA);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_r        <= IDLE;
            cuenta_r        <= 4'd0;
            timer_r         <= '0;
            carga_r         <= '0;
            error_r         <= 1'b0;
            reset_mineria_r <= 1'b0;
        end else begin
            estado_r        <= estado_s;
            cuenta_r        <= cuenta_s;
            timer_r         <= timer_s;
            carga_r         <= carga_s;
            error_r         <= error_s;
            reset_mineria_r <= reset_mineria_s;
        end
    end

endmodule

// File: tb/tb_cargador_bloque.sv
// Directed bench: dut_a uses the default timeout for nominal jobs, dut_b uses
// TIMEOUT=8 for the timeout and same-edge cases; both share the stream.
module tb_cargador_bloque;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        terminado = 1'b0;

    logic        byte_ready_a, inicio_a, reset_mineria_a, hecho_a, error_a;
    logic [95:0] bloque_a;
    logic [7:0]  target_a;
    logic        byte_ready_b, inicio_b, reset_mineria_b, hecho_b, error_b;
    logic [95:0] bloque_b;
    logic [7:0]  target_b;

    int n_checks = 0;
    int n_errors = 0;
    int n_hecho_a, n_rst_a, n_ini_a, n_seq_a, n_ini_b, n_hecho_b;
    logic prev_rst_a = 1'b0;
    logic prev_ini_a = 1'b0;

    typedef struct {
        logic [7:0]  base;
        logic [7:0]  paso;
        logic [7:0]  tgt;
        logic        stall;
        int          demora;
        logic [95:0] exp_bloque;
    } vec_t;

    vec_t tabla [5];

    cargador_bloque dut_a (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready_a), .terminado(terminado), .bloque_bytes(bloque_a),
        .target(target_a), .inicio(inicio_a), .reset_mineria(reset_mineria_a),
        .hecho(hecho_a), .error(error_a)
    );

    cargador_bloque #(.TIMEOUT(8)) dut_b (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready_b), .terminado(terminado), .bloque_bytes(bloque_b),
        .target(target_b), .inicio(inicio_b), .reset_mineria(reset_mineria_b),
        .hecho(hecho_b), .error(error_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [103:0] act, input logic [103:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        n_hecho_a = 0; n_rst_a = 0; n_ini_a = 0; n_seq_a = 0;
        n_ini_b = 0; n_hecho_b = 0;
    endtask

    // Advance one cycle and sample outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (hecho_a) n_hecho_a++;
        if (!reset_mineria_a) n_rst_a++;
        if (inicio_a) n_ini_a++;
        if (inicio_a && !prev_ini_a && !prev_rst_a) n_seq_a++;
        if (inicio_b) n_ini_b++;
        if (hecho_b) n_hecho_b++;
        prev_ini_a = inicio_a;
        prev_rst_a = !reset_mineria_a;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        chk("byte_ready", byte_ready_a, 1'b1);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_job(input logic [7:0] base, input logic [7:0] paso,
                            input logic [7:0] tgt, input logic stall);
        logic [7:0] b;
        for (int i = 0; i < 13; i++) begin
            if (stall) tick();
            b = base + (8'(i) * paso);
            if (i == 12) b = tgt;
            send_byte(b);
        end
    endtask

    initial begin
        tabla[0] = '{8'h01, 8'h01, 8'h40, 1'b0, 10, 96'h0102030405060708090A0B0C};
        tabla[1] = '{8'h01, 8'h01, 8'h40, 1'b1, 10, 96'h0102030405060708090A0B0C};
        tabla[2] = '{8'hF8, 8'h03, 8'h7F, 1'b0, 2,  96'hF8FBFE0104070A0D10131619};
        tabla[3] = '{8'hFF, 8'h00, 8'h00, 1'b0, 0,  96'hFFFFFFFFFFFFFFFFFFFFFFFF};
        tabla[4] = '{8'h80, 8'h11, 8'hC3, 1'b1, 7,  96'h8091A2B3C4D5E6F708192A3B};
        clr();

        // Power-on reset
        tick(); tick();
        chk("rst_rm_low", reset_mineria_a, 1'b0);
        chk("rst_ready", byte_ready_a, 1'b1);
        chk("rst_inicio", inicio_a, 1'b0);
        chk("rst_hecho", hecho_a, 1'b0);
        chk("rst_error", error_a, 1'b0);
        chk("rst_bloque", bloque_a, 96'h0);
        reset = 1'b1;
        #1;
        chk("rel_rm_still_low", reset_mineria_a, 1'b0);
        tick();
        chk("rel_rm_high", reset_mineria_a, 1'b1);
        chk("rel_ready", byte_ready_a, 1'b1);

        // Reset in the middle of a load
        for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i));
        chk("part_bloque", bloque_a, 96'h11121314);
        chk("part_target", target_a, 8'h15);
        reset = 1'b0;
        #1;
        chk("mid_rst_bloque", bloque_a, 96'h0);
        chk("mid_rst_target", target_a, 8'h0);
        chk("mid_rst_rm", reset_mineria_a, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rel_ready", byte_ready_a, 1'b1);
        chk("mid_rel_cuenta", dut_a.cuenta_r, 4'd0);
        chk("mid_rel_rm", reset_mineria_a, 1'b0);
        tick();
        chk("mid_rel_rm_high", reset_mineria_a, 1'b1);

        // Table of complete jobs on dut_a
        foreach (tabla[k]) begin
            clr();
            send_job(tabla[k].base, tabla[k].paso, tabla[k].tgt, tabla[k].stall);
            chk("limpia_ready", byte_ready_a, 1'b0);
            chk("limpia_rm", reset_mineria_a, 1'b0);
            chk("limpia_inicio", inicio_a, 1'b0);
            chk("limpia_bloque", bloque_a, tabla[k].exp_bloque);
            tick();
            chk("ejecuta_inicio", inicio_a, 1'b1);
            repeat (tabla[k].demora) tick();
            terminado = 1'b1;
            tick();
            chk("fin_hecho", hecho_a, 1'b1);
            chk("fin_inicio", inicio_a, 1'b0);
            terminado = 1'b0;
            tick();
            chk("idle_hecho", hecho_a, 1'b0);
            chk("idle_ready", byte_ready_a, 1'b1);
            chk("job_bloque", bloque_a, tabla[k].exp_bloque);
            chk("job_target", target_a, tabla[k].tgt);
            chk("job_error", error_a, 1'b0);
            chk("job_n_inicio", 32'(n_ini_a), 32'(tabla[k].demora + 1));
            chk("job_n_hecho", 32'(n_hecho_a), 32'd1);
            chk("job_n_rm_low", 32'(n_rst_a), 32'd1);
            chk("job_rm_before_inicio", 32'(n_seq_a), 32'd0);
        end

        // Timeout on dut_b (terminado held low)
        clr();
        send_job(8'h01, 8'h01, 8'h40, 1'b0);
        for (int w = 0; w < 30 && !hecho_b; w++) tick();
        chk("to_hecho", hecho_b, 1'b1);
        chk("to_error", error_b, 1'b1);
        chk("to_n_inicio", 32'(n_ini_b), 32'd8);
        chk("to_n_hecho", 32'(n_hecho_b), 32'd1);
        chk("to_a_running", inicio_a, 1'b1);
        tick();
        chk("to_hecho_off", hecho_b, 1'b0);
        chk("to_error_sticky", error_b, 1'b1);
        chk("to_ready_back", byte_ready_b, 1'b1);
        terminado = 1'b1;
        tick();
        chk("to_a_hecho", hecho_a, 1'b1);
        chk("to_a_error", error_a, 1'b0);
        terminado = 1'b0;
        tick();

        // terminado on the same edge as the last timer value: no error
        clr();
        send_job(8'h20, 8'h02, 8'h55, 1'b0);
        chk("sim_error_cleared", error_b, 1'b0);
        chk("sim_rm_low", reset_mineria_b, 1'b0);
        tick();
        repeat (7) tick();
        terminado = 1'b1;
        tick();
        chk("sim_hecho", hecho_b, 1'b1);
        chk("sim_error", error_b, 1'b0);
        chk("sim_n_inicio", 32'(n_ini_b), 32'd8);
        chk("sim_bloque", bloque_b, 96'h20222426282A2C2E30323436);
        tick();

        // Sticky terminado during load must not shortcut the job
        clr();
        send_job(8'hC0, 8'h01, 8'h99, 1'b1);
        chk("stk_n_inicio_load", 32'(n_ini_a), 32'd0);
        chk("stk_n_hecho_load", 32'(n_hecho_a), 32'd0);
        chk("stk_n_inicio_b", 32'(n_ini_b), 32'd0);
        chk("stk_limpia_inicio", inicio_a, 1'b0);
        tick();
        chk("stk_inicio", inicio_a, 1'b1);
        tick();
        chk("stk_hecho_a", hecho_a, 1'b1);
        chk("stk_error_a", error_a, 1'b0);
        chk("stk_hecho_b", hecho_b, 1'b1);
        chk("stk_n_inicio", 32'(n_ini_a), 32'd1);
        chk("stk_bloque", bloque_a, 96'hC0C1C2C3C4C5C6C7C8C9CACB);
        chk("stk_target", target_a, 8'h99);
        terminado = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
